key_debounce_sched: RTL and testbench

//  Time-shares one debounce counter across NUM_KEYS raw, active-low push-keys (50 MHz board clock).

---
 rtl/key_debounce_sched.sv | 134 +++++++++++++
 tb/tb_key_debounce_sched.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_sched.sv
// rtl/key_debounce_sched.sv - one debounce counter shared round-robin across active-low keys (optional KEY_BOUNCE_STAT_EN)
module key_debounce_sched #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int ID_W            = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keyin,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                busy,
`ifdef KEY_BOUNCE_STAT_EN
    output logic [15:0]         bounce_cnt,
`endif
    output logic [ID_W-1:0]     grant_id
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILTER = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_KEYS - 1);

    logic [1:0]          state;
    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] ksync;
    logic [NUM_KEYS-1:0] diff;
    logic [ID_W-1:0]     rr_ptr;
    logic [CNT_W-1:0]    cnt;
    logic [ID_W-1:0]     pick;
    logic [ID_W-1:0]     scan_idx;
    logic                pick_found;
    logic                abort;

    // Key index following i, wrapping at NUM_KEYS (which need not be a power of two)
    function automatic logic [ID_W-1:0] next_idx(input logic [ID_W-1:0] i);
        return (i == ID_LAST) ? '0 : i + 1'b1;
    endfunction

    assign diff  = ksync ^ key_state;
    assign busy  = (state != IDLE);
    // The granted key fell back to its committed level before the window closed
    assign abort = (state == FILTER) && !diff[grant_id];

    // Two-flop synchronizer; resets to "released" so no spurious window follows reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '1;
            ksync <= '1;
        end else begin
            sync1 <= keyin;
            ksync <= sync1;
        end
    end

    // Round-robin search for the first differing key starting at rr_ptr
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_idx   = rr_ptr;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!pick_found && diff[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
            scan_idx = next_idx(scan_idx);
        end
    end

    // Scheduler FSM: grant, filter the granted key for a stable window, commit with a pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            key_state   <= '1;
            key_press   <= '0;
            key_release <= '0;
            grant_id    <= '0;
            rr_ptr      <= '0;
            cnt         <= '0;
        end else begin
            key_press   <= '0;
            key_release <= '0;
            case (state)
                IDLE: begin
                    if (|diff) begin
                        grant_id <= pick;
                        cnt      <= '0;
                        state    <= FILTER;
                    end
                end
                FILTER: begin
                    if (abort) begin
                        rr_ptr <= next_idx(grant_id);
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        key_state[grant_id] <= ~key_state[grant_id];
                        if (key_state[grant_id]) begin
                            key_press[grant_id] <= 1'b1;
                        end else begin
                            key_release[grant_id] <= 1'b1;
                        end
                        state <= COMMIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    rr_ptr <= next_idx(grant_id);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_BOUNCE_STAT_EN
    // Saturating count of windows abandoned because the key bounced back
    always_ff @(posedge clk) begin
        if (rst) begin
            bounce_cnt <= '0;
        end else if (abort && bounce_cnt != 16'hFFFF) begin
            bounce_cnt <= bounce_cnt + 16'd1;
        end
    end
`else
    // Bounce statistics are not built in this configuration
`endif

endmodule

// File: tb/tb_key_debounce_sched.sv
// tb/tb_key_debounce_sched.sv - scoreboard bench for key_debounce_sched (D=16, 4 keys)
module tb_key_debounce_sched;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keyin = 4'hF;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       busy;
    logic [1:0] grant_id;
`ifdef KEY_BOUNCE_STAT_EN
    logic [15:0] bounce_cnt;
`endif

    key_debounce_sched #(
        .NUM_KEYS(4),
        .DEBOUNCE_CYCLES(D),
        .CNT_W(20),
        .ID_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .keyin(keyin),
        .key_state(key_state),
        .key_press(key_press),
        .key_release(key_release),
        .busy(busy),
`ifdef KEY_BOUNCE_STAT_EN
        .bounce_cnt(bounce_cnt),
`endif
        .grant_id(grant_id)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [3:0] press;
        logic [3:0] rel;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_pulse(input logic [3:0] press, input logic [3:0] rel, input int at);
        exp_t e;
        e.press = press;
        e.rel   = rel;
        e.at    = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        check("rst_key_state", key_state, 4'hF);
        check("rst_pulses", {key_press, key_release}, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
`ifdef KEY_BOUNCE_STAT_EN
        check("rst_bounce_cnt", bounce_cnt, 16'd0);
`endif
        rst = 1'b0;
    endtask

    // Monitor: every pulse is popped against the scoreboard, including its cycle
    always @(negedge clk) begin
        if ((key_press | key_release) != 4'h0) begin
            check("pulse_onehot", $countones(key_press | key_release), 1);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {key_press, key_release}, 8'h00);
            end else begin
                mon_e = exp_q.pop_front();
                check("press_vec", key_press, mon_e.press);
                check("release_vec", key_release, mon_e.rel);
                check("pulse_cycle", cyc, mon_e.at);
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        // 1 Reset
        keyin = 4'hF;
        @(negedge clk);
        do_reset(5);
        repeat (3) @(negedge clk);

        // 2 Clean press and release of key0
        keyin = 4'hE;
        expect_pulse(4'h1, 4'h0, cyc + 19);
        wait_drain("drain_press0", 60);
        check("press0_key_state", key_state, 4'hE);
        check("press0_busy", busy, 1'b0);
        keyin = 4'hF;
        expect_pulse(4'h0, 4'h1, cyc + 19);
        wait_drain("drain_release0", 60);
        check("release0_key_state", key_state, 4'hF);

        // 3 Bounce on key1: seven levels 5 clks apart ending low
        for (int i = 0; i < 7; i++) begin
            keyin[1] = i[0];
            if (i < 6) repeat (5) @(negedge clk);
        end
        expect_pulse(4'h2, 4'h0, cyc + 19);
        wait_drain("drain_bounce", 80);
        check("bounce_key_state", key_state, 4'hD);
`ifdef KEY_BOUNCE_STAT_EN
        check("bounce_cnt", bounce_cnt, 16'd3);
`endif
        keyin = 4'hF;
        expect_pulse(4'h0, 4'h2, cyc + 19);
        wait_drain("drain_release1", 60);
        check("release1_grant_id", grant_id, 2'd1);
        do_reset(3);
        repeat (2) @(negedge clk);

        // 4 Simultaneous press from rr_ptr=0
        keyin = 4'h0;
        c = cyc;
        expect_pulse(4'h1, 4'h0, c + 19);
        expect_pulse(4'h2, 4'h0, c + 37);
        expect_pulse(4'h4, 4'h0, c + 55);
        expect_pulse(4'h8, 4'h0, c + 73);
        wait_drain("drain_simul", 150);
        check("simul_key_state", key_state, 4'h0);
        check("simul_grant_id", grant_id, 2'd3);

        // 5 Round-robin: key2 leaves rr_ptr=3, so key3 beats key0
        keyin = 4'h4;
        expect_pulse(4'h0, 4'h4, cyc + 19);
        wait_drain("drain_rr_key2", 60);
        keyin = 4'hD;
        c = cyc;
        expect_pulse(4'h0, 4'h8, c + 19);
        expect_pulse(4'h0, 4'h1, c + 37);
        wait_drain("drain_rr", 100);
        check("rr_key_state", key_state, 4'hD);
        check("rr_grant_id", grant_id, 2'd0);

        // 6 Reset in the middle of key0's window
        keyin = 4'hF;
        do_reset(3);
        repeat (2) @(negedge clk);
        keyin = 4'hE;
        repeat (11) @(negedge clk);
        check("midwin_busy", busy, 1'b1);
        do_reset(3);
        expect_pulse(4'h1, 4'h0, cyc + 19);
        wait_drain("drain_after_reset", 60);
        check("after_reset_key_state", key_state, 4'hE);
`ifdef KEY_BOUNCE_STAT_EN
        check("after_reset_bounce_cnt", bounce_cnt, 16'd0);
`endif

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
